// File: rtl/sine_sum_pkg.sv
// Shared widths, helper functions and quadrant encoding for the multi-tone sine summer.
// Optional phase offset feature is controlled by SINE_SUM_PHASE_OFS_EN.
package sine_sum_pkg;

  localparam int DEF_NCH     = 4;
  localparam int DEF_PHASE_W = 12;
  localparam int DEF_DATA_W  = 12;

  typedef enum logic [1:0] {
    QUAD_RISE     = 2'd0,
    QUAD_FALL     = 2'd1,
    QUAD_NEG_FALL = 2'd2,
    QUAD_NEG_RISE = 2'd3
  } quad_e;

  function automatic int clog2_ch(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sum_width(input int data_w, input int nch);
    return data_w + clog2_ch(nch);
  endfunction

endpackage

// File: rtl/sine_nco_ch.sv
// One NCO channel: phase accumulator, optional phase offset (SINE_SUM_PHASE_OFS_EN)
// and quarter-wave sine lookup with a registered sample output.
module sine_nco_ch
  import sine_sum_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               ch_en,
  input  logic [PHASE_W-1:0] delta,
`ifdef SINE_SUM_PHASE_OFS_EN
  input  logic               ofs_we,
  input  logic [PHASE_W-1:0] ofs,
`endif
  output logic [DATA_W-1:0]  sample
);

  localparam int QW    = PHASE_W - 2;
  localparam int QN    = 1 << QW;
  localparam int MAG_W = DATA_W - 1;
  localparam real PI   = 3.14159265358979323846;
  localparam real AMP  = $itor((1 << MAG_W) - 1);
  localparam logic [DATA_W-1:0] MID  = {1'b1, {MAG_W{1'b0}}};
  localparam logic [MAG_W-1:0]  PEAK = {MAG_W{1'b1}};

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] addr;
  logic               ch_en_q;
  logic [MAG_W-1:0]   qtab [QN];
  logic [QW-1:0]      idx;
  logic [QW-1:0]      mir;
  logic [MAG_W-1:0]   mag;
  quad_e              quad;

  // Quarter-wave magnitudes, rounded half away from zero, fixed at elaboration
  for (genvar i = 0; i < QN; i++) begin : g_tab
    localparam real ANG = 2.0 * PI * $itor(i) / $itor(1 << PHASE_W);
    localparam int  QV  = $rtoi($floor(AMP * $sin(ANG) + 0.5));
    assign qtab[i] = MAG_W'(QV);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= '0;
      ch_en_q <= 1'b0;
    end else begin
      ch_en_q <= ch_en;
      if (phase_clr)
        phase <= '0;
      else if (en && ch_en)
        phase <= phase + delta;
    end
  end

`ifdef SINE_SUM_PHASE_OFS_EN
  logic [PHASE_W-1:0] ofs_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ofs_q <= '0;
    else if (ofs_we)
      ofs_q <= ofs;
  end

  assign addr = phase + ofs_q;
`else
  assign addr = phase;
`endif

  assign mir = -idx;

  // Odd quadrants read the table backwards; index 0 there is the peak, one past the table end
  always_comb begin
    quad = quad_e'(addr[PHASE_W-1 -: 2]);
    idx  = addr[QW-1:0];
    mag  = qtab[idx];
    if (quad == QUAD_FALL || quad == QUAD_NEG_RISE)
      mag = (idx == '0) ? PEAK : qtab[mir];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sample <= '0;
    else if (!ch_en_q)
      sample <= '0;
    else if (quad == QUAD_NEG_FALL || quad == QUAD_NEG_RISE)
      sample <= MID - {1'b0, mag};
    else
      sample <= MID + {1'b0, mag};
  end

endmodule

// File: rtl/sine_sum_multi.sv
// N-channel DDS with double-buffered frequency words and a registered adder tree.
// Define SINE_SUM_PHASE_OFS_EN to add per-channel phase offset ports.
module sine_sum_multi
  import sine_sum_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int CH_W   = clog2_ch(NCH),
  localparam int SUM_W  = sum_width(DATA_W, NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [NCH-1:0]     ch_en,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_delta,
  input  logic               cfg_commit,
`ifdef SINE_SUM_PHASE_OFS_EN
  input  logic               cfg_ofs_we,
  input  logic [PHASE_W-1:0] cfg_ofs,
`endif
  output logic [SUM_W-1:0]   sum_out,
  output logic               sum_valid
);

  localparam int LAT = 2 + CH_W;

  logic [NCH-1:0]     ch_sel;
  logic [PHASE_W-1:0] shadow [NCH];
  logic [PHASE_W-1:0] active [NCH];
  logic [DATA_W-1:0]  sample [NCH];
  logic [SUM_W-1:0]   node   [NCH-1];
  logic [SUM_W-1:0]   tree_n [2*NCH-1];
  logic [LAT-1:0]     vld_sr;

  always_comb begin
    ch_sel = '0;
    for (int ch = 0; ch < NCH; ch++)
      ch_sel[ch] = (32'(cfg_ch) == ch);
  end

  // A write landing in the commit cycle is forwarded straight into the active delta
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        shadow[ch] <= '0;
        active[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (cfg_we && ch_sel[ch])
          shadow[ch] <= cfg_delta;
        if (cfg_commit)
          active[ch] <= (cfg_we && ch_sel[ch]) ? cfg_delta : shadow[ch];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sine_nco_ch #(
      .PHASE_W (PHASE_W),
      .DATA_W  (DATA_W)
    ) u_nco (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .phase_clr (phase_clr),
      .ch_en     (ch_en[g]),
      .delta     (active[g]),
`ifdef SINE_SUM_PHASE_OFS_EN
      .ofs_we    (cfg_ofs_we && ch_sel[g]),
      .ofs       (cfg_ofs),
`endif
      .sample    (sample[g])
    );
  end

  // Heap-ordered tree: node i sums children 2i+1 and 2i+2, leaves are the channel samples
  always_comb begin
    for (int i = 0; i < 2*NCH-1; i++)
      tree_n[i] = '0;
    for (int i = 0; i < NCH-1; i++)
      tree_n[i] = node[i];
    for (int g = 0; g < NCH; g++)
      tree_n[NCH-1+g] = SUM_W'(sample[g]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH-1; i++)
        node[i] <= '0;
    end else begin
      for (int i = 0; i < NCH-1; i++)
        node[i] <= tree_n[2*i+1] + tree_n[2*i+2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld_sr <= '0;
    else
      vld_sr <= {vld_sr[LAT-2:0], en};
  end

  assign sum_out   = node[0];
  assign sum_valid = vld_sr[LAT-1];

endmodule

// File: tb/tb_sine_sum_multi.sv
// Self-checking bench for sine_sum_multi: directed scenarios plus randomized traffic
// compared every cycle against a behavioural sine/phase model.
module tb_sine_sum_multi;

  localparam int NCH = 4;
  localparam int LAT = 4;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        phase_clr;
  logic [3:0]  ch_en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [11:0] cfg_delta;
  logic        cfg_commit;
  logic [13:0] sum_out;
  logic        sum_valid;

  int errors = 0;
  int checks = 0;

  int m_sh [NCH];
  int m_act[NCH];
  int m_ph [NCH];
  bit q_v[$];
  int q_s[$];
  bit cur_v;
  int cur_s;

  always #5 clk = ~clk;

  sine_sum_multi dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .phase_clr  (phase_clr),
    .ch_en      (ch_en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_delta  (cfg_delta),
    .cfg_commit (cfg_commit),
`ifdef SINE_SUM_PHASE_OFS_EN
    .cfg_ofs_we (1'b0),
    .cfg_ofs    (12'd0),
`endif
    .sum_out    (sum_out),
    .sum_valid  (sum_valid)
  );

  function automatic int s_model(input int p);
    real y;
    int  m;
    y = 2047.0 * $sin(2.0 * PI * p / 4096.0);
    m = $rtoi($floor(((y < 0.0) ? -y : y) + 0.5));
    return (y < 0.0) ? 2048 - m : 2048 + m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sh[c] = 0; m_act[c] = 0; m_ph[c] = 0;
    end
    q_v.delete();
    q_s.delete();
    for (int k = 0; k < LAT-1; k++) begin
      q_v.push_back(1'b0);
      q_s.push_back(0);
    end
    cur_v = 1'b0;
    cur_s = 0;
  endtask

  // One clock edge of the reference: phases move with the old deltas, then config updates
  task automatic model_edge();
    int np[NCH];
    int sum;
    sum = 0;
    for (int c = 0; c < NCH; c++) begin
      if (phase_clr)            np[c] = 0;
      else if (en && ch_en[c])  np[c] = (m_ph[c] + m_act[c]) % 4096;
      else                      np[c] = m_ph[c];
      if (ch_en[c]) sum += s_model(np[c]);
    end
    for (int c = 0; c < NCH; c++) begin
      if (cfg_commit)
        m_act[c] = (cfg_we && int'(cfg_ch) == c) ? int'(cfg_delta) : m_sh[c];
      if (cfg_we && int'(cfg_ch) == c)
        m_sh[c] = int'(cfg_delta);
      m_ph[c] = np[c];
    end
    q_v.push_back(en);
    q_s.push_back(sum);
    cur_v = q_v.pop_front();
    cur_s = q_s.pop_front();
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_sum", int'(sum_out), 0);
      chk("rst_valid", int'(sum_valid), 0);
    end else begin
      chk("valid", int'(sum_valid), int'(cur_v));
      if (cur_v) chk("sum", int'(sum_out), cur_s);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t2[4];
    int n;
    t2 = '{4095, 2048, 1, 2048};
    rst = 1'b1; en = 1'b0; phase_clr = 1'b0; ch_en = 4'h0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_delta = 12'd0; cfg_commit = 1'b0;
    model_reset();
    #1 rst = 1'b0;

    chk("model_s0", s_model(0), 2048);
    chk("model_s1024", s_model(1024), 4095);
    chk("model_s2048", s_model(2048), 2048);
    chk("model_s3072", s_model(3072), 1);
    chk("model_s4095", s_model(4095), 2045);

    repeat (3) step();
    rst = 1'b1;

    // all channels at midscale
    ch_en = 4'hF; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k >= LAT) begin
        chk("t1_valid", int'(sum_valid), 1);
        chk("t1_sum", int'(sum_out), 8192);
      end else begin
        chk("t1_lat", int'(sum_valid), 0);
      end
    end
    en = 1'b0;

    // quarter-turn steps on ch0
    ch_en = 4'h1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delta = 12'd1024;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0; en = 1'b1;
    repeat (4) step();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", int'(sum_valid), 1);
      chk("t2_sum", int'(sum_out), t2[i]);
      step();
    end

    // shadow write, then commit coinciding with en
    ch_en = 4'h3; en = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_delta = 12'd512;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    en = 1'b0;
    step();
    chk("t3_sum_a", int'(sum_out), 6143);
    step();
    chk("t3_sum_b", int'(sum_out), 4096);
    step();
    chk("t3_sum_c", int'(sum_out), 3496);

    // phase clear beats en
    ch_en = 4'h1; en = 1'b1;
    step();
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0; en = 1'b0;
    repeat (3) step();
    chk("t4_clr_sum", int'(sum_out), 2048);

    // wrap-around with delta 4095
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delta = 12'd4095; cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0; en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    repeat (2) step();
    chk("t5_wrap_a", int'(sum_out), 2045);
    step();
    chk("t5_wrap_b", int'(sum_out), s_model(4094));

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      en         = ($urandom_range(3) != 0);
      phase_clr  = ($urandom_range(40) == 0);
      ch_en      = 4'($urandom);
      cfg_we     = ($urandom_range(5) == 0);
      cfg_ch     = 2'($urandom);
      cfg_delta  = 12'($urandom);
      cfg_commit = ($urandom_range(15) == 0);
      step();
    end
    phase_clr = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;

    // asynchronous reset mid-stream
    ch_en = 4'hF; en = 1'b1;
    repeat (LAT+2) step();
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_async_sum", int'(sum_out), 0);
    chk("t6_async_valid", int'(sum_valid), 0);
    en = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!sum_valid && n < 10);
    chk("t6_first_valid_lat", n, LAT);
    chk("t6_sum_after_rst", int'(sum_out), 8192);
    en = 1'b0;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
